sram_load_sequencer: RTL and testbench

Parametrised successor to the single-image/coefficient SRAM controller. It sequences one image load followed by NUM_LAYERS coefficient-layer loads for the ANN datapath. For each load it issues start_sram with a base address and word count, tracks the layer index and guards every wait with a watchdog. It sits between the ANN controller (start_detecting, request_coef, done_processing) and the SRAM read engine (start_sram, sram_done).

---
 rtl/sram_seq_pkg.sv | 31 +++
 rtl/sram_watchdog.sv | 31 +++
 rtl/sram_load_sequencer.sv | 151 +++++++++++++++
 tb/tb_sram_load_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_seq_pkg.sv
// Shared types and the coefficient-address helper for the SRAM load sequencer.
`default_nettype none

package sram_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_IMG_START  = 3'd1,
    S_IMG_WAIT   = 3'd2,
    S_COEF_IDLE  = 3'd3,
    S_COEF_START = 3'd4,
    S_COEF_WAIT  = 3'd5,
    S_ALL_LOADED = 3'd6,
    S_ERROR      = 3'd7
  } state_t;

  typedef enum logic {
    MODE_IMAGE = 1'b0,
    MODE_COEF  = 1'b1
  } load_mode_t;

  // Base of a coefficient layer; caller truncates to its address width.
  function automatic logic [31:0] coef_addr(input logic [31:0] base,
                                            input logic [31:0] idx,
                                            input logic [31:0] words);
    return base + idx * words;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_watchdog.sv
// Wait-state watchdog: counts enabled cycles and flags when TIMEOUT_CYCLES-1 is reached.
`default_nettype none

module sram_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/sram_load_sequencer.sv
// Sequences one image load then NUM_LAYERS coefficient loads into the SRAM read engine,
// with sticky protocol/timeout errors and a per-wait watchdog.
`default_nettype none

module sram_load_sequencer
  import sram_seq_pkg::*;
#(
  parameter int                NUM_LAYERS     = 2,
  parameter int                ADDR_W         = 16,
  parameter int                LEN_W          = 16,
  parameter logic [ADDR_W-1:0] IMG_BASE       = 16'h0000,
  parameter int                IMG_WORDS      = 1024,
  parameter logic [ADDR_W-1:0] COEF_BASE      = 16'h0400,
  parameter int                COEF_WORDS     = 256,
  parameter int                TIMEOUT_CYCLES = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_detecting,
  input  logic                              request_coef,
  input  logic                              done_processing,
  input  logic                              sram_done,
  output logic                              start_sram,
  output logic [ADDR_W-1:0]                 sram_addr,
  output logic [LEN_W-1:0]                  sram_len,
  output logic                              n_coef_image,
  output logic                              image_weights_loaded,
  output logic [$clog2(NUM_LAYERS+1)-1:0]   layer_idx,
  output logic                              busy,
  output logic                              all_loaded,
  output logic                              err_protocol,
  output logic                              err_timeout
);

  localparam int LW = $clog2(NUM_LAYERS + 1);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS);

  state_t        state;
  logic          waiting;
  logic          wd_expired;
  logic [LW-1:0] next_layer;

  assign waiting    = (state == S_IMG_WAIT) || (state == S_COEF_WAIT);
  assign next_layer = layer_idx + 1'b1;

  // Held clear outside WAIT states, so every WAIT entry starts from zero.
  sram_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!waiting),
    .enable (waiting),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      start_sram           <= 1'b0;
      sram_addr            <= '0;
      sram_len             <= '0;
      n_coef_image         <= 1'b0;
      image_weights_loaded <= 1'b0;
      layer_idx            <= '0;
      busy                 <= 1'b0;
      all_loaded           <= 1'b0;
      err_protocol         <= 1'b0;
      err_timeout          <= 1'b0;
    end else begin
      start_sram <= 1'b0;
      if (done_processing) begin
        state                <= S_IDLE;
        busy                 <= 1'b0;
        layer_idx            <= '0;
        image_weights_loaded <= 1'b0;
        all_loaded           <= 1'b0;
        err_protocol         <= 1'b0;
        err_timeout          <= 1'b0;
      end else begin
        if (start_detecting && (state != S_IDLE))
          err_protocol <= 1'b1;
        if (request_coef && ((state == S_IDLE) || (state == S_IMG_START) ||
                             (state == S_IMG_WAIT) || (state == S_ALL_LOADED)))
          err_protocol <= 1'b1;
        if (sram_done && !waiting)
          err_protocol <= 1'b1;

        case (state)
          S_IDLE: begin
            if (start_detecting) begin
              state        <= S_IMG_START;
              start_sram   <= 1'b1;
              sram_addr    <= IMG_BASE;
              sram_len     <= LEN_W'(IMG_WORDS);
              n_coef_image <= MODE_IMAGE;
              busy         <= 1'b1;
            end
          end
          S_IMG_START: state <= S_IMG_WAIT;
          S_IMG_WAIT: begin
            // sram_done beats a watchdog expiry landing on the same cycle.
            if (sram_done) begin
              state                <= S_COEF_IDLE;
              image_weights_loaded <= 1'b1;
              busy                 <= 1'b0;
            end else if (wd_expired) begin
              state       <= S_ERROR;
              err_timeout <= 1'b1;
              busy        <= 1'b0;
            end
          end
          S_COEF_IDLE: begin
            if (request_coef) begin
              state        <= S_COEF_START;
              start_sram   <= 1'b1;
              sram_addr    <= ADDR_W'(coef_addr(32'(COEF_BASE), 32'(layer_idx),
                                                32'(COEF_WORDS)));
              sram_len     <= LEN_W'(COEF_WORDS);
              n_coef_image <= MODE_COEF;
              busy         <= 1'b1;
            end
          end
          S_COEF_START: state <= S_COEF_WAIT;
          S_COEF_WAIT: begin
            if (sram_done) begin
              layer_idx <= next_layer;
              busy      <= 1'b0;
              if (next_layer == LAST_LAYER) begin
                state      <= S_ALL_LOADED;
                all_loaded <= 1'b1;
              end else begin
                state <= S_COEF_IDLE;
              end
            end else if (wd_expired) begin
              state       <= S_ERROR;
              err_timeout <= 1'b1;
              busy        <= 1'b0;
            end
          end
          S_ALL_LOADED: state <= S_ALL_LOADED;
          S_ERROR:      state <= S_ERROR;
          default:      state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_load_sequencer.sv
// Directed self-checking bench for sram_load_sequencer (TIMEOUT_CYCLES=16).
`default_nettype none

module tb_sram_load_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_detecting, request_coef, done_processing, sram_done;
  logic        start_sram, n_coef_image, image_weights_loaded, busy, all_loaded;
  logic        err_protocol, err_timeout;
  logic [15:0] sram_addr, sram_len;
  logic [1:0]  layer_idx;

  int checks   = 0;
  int failures = 0;

  sram_load_sequencer #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start_detecting     (start_detecting),
    .request_coef        (request_coef),
    .done_processing     (done_processing),
    .sram_done           (sram_done),
    .start_sram          (start_sram),
    .sram_addr           (sram_addr),
    .sram_len            (sram_len),
    .n_coef_image        (n_coef_image),
    .image_weights_loaded(image_weights_loaded),
    .layer_idx           (layer_idx),
    .busy                (busy),
    .all_loaded          (all_loaded),
    .err_protocol        (err_protocol),
    .err_timeout         (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start_detecting = 1'b1; tick(); start_detecting = 1'b0;
  endtask

  task automatic pulse_coef();
    request_coef = 1'b1; tick(); request_coef = 1'b0;
  endtask

  task automatic pulse_done();
    sram_done = 1'b1; tick(); sram_done = 1'b0;
  endtask

  task automatic pulse_finish();
    done_processing = 1'b1; tick(); done_processing = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_detecting = 1'b0; request_coef = 1'b0;
    done_processing = 1'b0; sram_done = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("rst_start", 32'(start_sram), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_len", 32'(sram_len), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_img", 32'(image_weights_loaded), 0);
    chk("rst_layer", 32'(layer_idx), 0);
    chk("rst_errs", {30'd0, err_protocol, err_timeout}, 0);

    // Nominal image load
    pulse_start();
    chk("img_start", 32'(start_sram), 1);
    chk("img_addr", 32'(sram_addr), 32'h0000);
    chk("img_len", 32'(sram_len), 1024);
    chk("img_mode", 32'(n_coef_image), 0);
    chk("img_busy", 32'(busy), 1);
    tick();
    chk("img_start_1cyc", 32'(start_sram), 0);
    chk("img_wait_busy", 32'(busy), 1);
    tick(4);
    pulse_done();
    chk("img_loaded", 32'(image_weights_loaded), 1);
    chk("img_idle_busy", 32'(busy), 0);

    // Coefficient layers 0 and 1
    pulse_coef();
    chk("c0_start", 32'(start_sram), 1);
    chk("c0_addr", 32'(sram_addr), 32'h0400);
    chk("c0_len", 32'(sram_len), 256);
    chk("c0_mode", 32'(n_coef_image), 1);
    tick(3);
    pulse_done();
    chk("c0_layer", 32'(layer_idx), 1);
    chk("c0_all", 32'(all_loaded), 0);
    pulse_coef();
    chk("c1_start", 32'(start_sram), 1);
    chk("c1_addr", 32'(sram_addr), 32'h0500);
    tick(2);
    pulse_done();
    chk("c1_layer", 32'(layer_idx), 2);
    chk("c1_all", 32'(all_loaded), 1);
    chk("c1_busy", 32'(busy), 0);
    pulse_coef();
    chk("all_req_err", 32'(err_protocol), 1);
    chk("all_req_nostart", 32'(start_sram), 0);
    chk("all_hold", 32'(all_loaded), 1);
    pulse_finish();
    chk("fin_layer", 32'(layer_idx), 0);
    chk("fin_img", 32'(image_weights_loaded), 0);
    chk("fin_all", 32'(all_loaded), 0);
    chk("fin_err", 32'(err_protocol), 0);

    // Protocol errors
    pulse_coef();
    chk("idle_req_err", 32'(err_protocol), 1);
    chk("idle_req_nostart", 32'(start_sram), 0);
    pulse_start();
    chk("idle_still_start", 32'(start_sram), 1);
    tick();
    pulse_finish();
    chk("wait_fin_err", 32'(err_protocol), 0);
    chk("wait_fin_busy", 32'(busy), 0);
    pulse_start();
    tick();
    start_detecting = 1'b1; sram_done = 1'b1; tick();
    start_detecting = 1'b0; sram_done = 1'b0;
    chk("both_img", 32'(image_weights_loaded), 1);
    chk("both_err", 32'(err_protocol), 1);
    pulse_finish();
    pulse_start();
    tick();
    pulse_done();
    chk("pre_stray_err", 32'(err_protocol), 0);
    pulse_done();
    chk("stray_err", 32'(err_protocol), 1);
    chk("stray_layer", 32'(layer_idx), 0);
    chk("stray_img", 32'(image_weights_loaded), 1);
    pulse_finish();

    // Watchdog expiry: error visible 16 edges after IMG_WAIT entry
    pulse_start();
    tick();
    tick(15);
    chk("to_not_yet", 32'(err_timeout), 0);
    chk("to_busy_yet", 32'(busy), 1);
    tick();
    chk("to_err", 32'(err_timeout), 1);
    chk("to_busy", 32'(busy), 0);
    pulse_coef();
    chk("err_req_nostart", 32'(start_sram), 0);
    tick();
    chk("err_req_nostart2", 32'(start_sram), 0);
    pulse_finish();
    chk("to_clear", {30'd0, err_protocol, err_timeout}, 0);

    // sram_done on the expiry cycle wins
    pulse_start();
    tick();
    tick(15);
    pulse_done();
    chk("edge_done_img", 32'(image_weights_loaded), 1);
    chk("edge_done_noto", 32'(err_timeout), 0);

    // done_processing beats sram_done in COEF_WAIT
    pulse_coef();
    tick();
    done_processing = 1'b1; sram_done = 1'b1; tick();
    done_processing = 1'b0; sram_done = 1'b0;
    chk("prio_layer", 32'(layer_idx), 0);
    chk("prio_all", 32'(all_loaded), 0);
    chk("prio_busy", 32'(busy), 0);
    chk("prio_err", 32'(err_protocol), 0);

    // Reset mid-load
    pulse_start();
    tick(2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_addr", 32'(sram_addr), 0);
    chk("rstmid_len", 32'(sram_len), 0);
    tick(2);
    chk("rstmid_nostart", 32'(start_sram), 0);
    pulse_start();
    chk("restart_start", 32'(start_sram), 1);
    chk("restart_addr", 32'(sram_addr), 32'h0000);
    chk("restart_len", 32'(sram_len), 1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
